hdmi_timing_gen: RTL and testbench

- Parametrised successor to the fixed-mode HDMI sync/DE generator.
- Produces hsync, vsync and DE for two compile-time video modes (A = 720p60, B = 1080p60), selectable at runtime. Mode changes take effect only on a frame boundary.
- Outputs active-area pixel coordinates ahead of sync/DE, so a pixel source (gen_pat or similar) with PIPE_DLY cycles of latency lines up with DE.
- Adds run/stop control and frame_start/line_start strobes. Sits between the PLL pixel clock domain and the pattern generator/HDMI transmitter pins.

---
 rtl/hdmi_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// HDMI sync/DE generator with two compile-time video modes, run/stop control,
// active-area pixel coordinates and a PIPE_DLY-deep sync/DE pipeline.
module hdmi_timing_gen #(
  parameter int unsigned CW       = 12,
  parameter int unsigned PIPE_DLY = 1,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned A_HSYNC  = 40,
  parameter int unsigned A_HBP    = 220,
  parameter int unsigned A_HACT   = 1280,
  parameter int unsigned A_HFP    = 110,
  parameter int unsigned A_VSYNC  = 5,
  parameter int unsigned A_VBP    = 20,
  parameter int unsigned A_VACT   = 720,
  parameter int unsigned A_VFP    = 5,
  parameter int unsigned B_HSYNC  = 44,
  parameter int unsigned B_HBP    = 148,
  parameter int unsigned B_HACT   = 1920,
  parameter int unsigned B_HFP    = 88,
  parameter int unsigned B_VSYNC  = 5,
  parameter int unsigned B_VBP    = 36,
  parameter int unsigned B_VACT   = 1080,
  parameter int unsigned B_VFP    = 4
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          en,
  input  logic          mode_sel,
  output logic          mode_cur,
  output logic          running,
  output logic [CW-1:0] loc_x,
  output logic [CW-1:0] loc_y,
  output logic          loc_valid,
  output logic          hdmi_hsync,
  output logic          hdmi_vsync,
  output logic          hdmi_de,
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned A_HTOT = A_HSYNC + A_HBP + A_HACT + A_HFP;
  localparam int unsigned A_VTOT = A_VSYNC + A_VBP + A_VACT + A_VFP;
  localparam int unsigned B_HTOT = B_HSYNC + B_HBP + B_HACT + B_HFP;
  localparam int unsigned B_VTOT = B_VSYNC + B_VBP + B_VACT + B_VFP;
  localparam int unsigned CNT_LIM = 1 << CW;

  if (B_HTOT >= CNT_LIM || B_VTOT >= CNT_LIM || A_HTOT >= CNT_LIM || A_VTOT >= CNT_LIM) begin : g_width_chk
    $error("hdmi_timing_gen: timing totals do not fit in CW bits");
  end
  if (PIPE_DLY > 7) begin : g_dly_chk
    $error("hdmi_timing_gen: PIPE_DLY must be 0..7");
  end

  // Pipeline payload order: {frame_start, line_start, de, vsync, hsync}
  localparam logic [4:0] PIPE_RST = {3'b000, ~VS_POL, ~HS_POL};

  logic          r_mode_cur;
  logic          r_running;
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [CW-1:0] r_loc_x;
  logic [CW-1:0] r_loc_y;
  logic          r_loc_valid;
  logic [4:0]    r_stage1;

  logic [CW-1:0] w_htot_m1, w_hsync, w_hstart, w_hend;
  logic [CW-1:0] w_vtot_m1, w_vsync, w_vstart, w_vend;
  logic          w_h_last, w_v_last, w_bound;
  logic          w_valid, w_hs, w_vs, w_ls, w_fs;
  logic [4:0]    w_out;

  // Per-mode timing constants, selected by the mode currently generated
  always_comb begin
    w_htot_m1 = CW'(A_HTOT - 1);
    w_hsync   = CW'(A_HSYNC);
    w_hstart  = CW'(A_HSYNC + A_HBP);
    w_hend    = CW'(A_HSYNC + A_HBP + A_HACT);
    w_vtot_m1 = CW'(A_VTOT - 1);
    w_vsync   = CW'(A_VSYNC);
    w_vstart  = CW'(A_VSYNC + A_VBP);
    w_vend    = CW'(A_VSYNC + A_VBP + A_VACT);
    if (r_mode_cur) begin
      w_htot_m1 = CW'(B_HTOT - 1);
      w_hsync   = CW'(B_HSYNC);
      w_hstart  = CW'(B_HSYNC + B_HBP);
      w_hend    = CW'(B_HSYNC + B_HBP + B_HACT);
      w_vtot_m1 = CW'(B_VTOT - 1);
      w_vsync   = CW'(B_VSYNC);
      w_vstart  = CW'(B_VSYNC + B_VBP);
      w_vend    = CW'(B_VSYNC + B_VBP + B_VACT);
    end
  end

  assign w_h_last = (r_h_cnt == w_htot_m1);
  assign w_v_last = (r_v_cnt == w_vtot_m1);
  // Every stopped cycle is a boundary, so a start takes effect on the next edge
  assign w_bound  = !r_running || (w_h_last && w_v_last);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_cur <= 1'b0;
      r_running  <= 1'b0;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
    end else if (w_bound) begin
      r_mode_cur <= mode_sel;
      r_running  <= en;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
    end else if (w_h_last) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= r_v_cnt + CW'(1);
    end else begin
      r_h_cnt    <= r_h_cnt + CW'(1);
    end
  end

  assign w_valid = r_running && (r_h_cnt >= w_hstart) && (r_h_cnt < w_hend)
                             && (r_v_cnt >= w_vstart) && (r_v_cnt < w_vend);
  assign w_hs    = (r_running && (r_h_cnt < w_hsync)) ? HS_POL : ~HS_POL;
  assign w_vs    = (r_running && (r_v_cnt < w_vsync)) ? VS_POL : ~VS_POL;
  assign w_ls    = r_running && (r_h_cnt == '0);
  assign w_fs    = w_ls && (r_v_cnt == '0);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_loc_valid <= 1'b0;
      r_loc_x     <= '0;
      r_loc_y     <= '0;
      r_stage1    <= PIPE_RST;
    end else begin
      r_loc_valid <= w_valid;
      r_loc_x     <= w_valid ? (r_h_cnt - w_hstart) : '0;
      r_loc_y     <= w_valid ? (r_v_cnt - w_vstart) : '0;
      r_stage1    <= {w_fs, w_ls, w_valid, w_vs, w_hs};
    end
  end

  // Extra delay so a PIPE_DLY-latency pixel source lines up with DE
  if (PIPE_DLY == 0) begin : g_nodly
    assign w_out = r_stage1;
  end else begin : g_dly
    logic [4:0] r_dly [PIPE_DLY];
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) r_dly[i] <= PIPE_RST;
      end else begin
        r_dly[0] <= r_stage1;
        for (int i = 1; i < int'(PIPE_DLY); i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_out = r_dly[PIPE_DLY-1];
  end

  assign mode_cur  = r_mode_cur;
  assign running   = r_running;
  assign loc_x     = r_loc_x;
  assign loc_y     = r_loc_y;
  assign loc_valid = r_loc_valid;
  assign {frame_start, line_start, hdmi_de, hdmi_vsync, hdmi_hsync} = w_out;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen: three instances with reduced timings
// (PIPE_DLY 1/0/3, the PIPE_DLY=0 one with low-active syncs) share stimulus.
module tb_hdmi_timing_gen;

  localparam int unsigned CW = 12;
  // Mode A: HTOT 17, VTOT 10, active h 7..14, v 4..8
  localparam int unsigned AHS = 4, AHB = 3, AHA = 8,  AHF = 2;
  localparam int unsigned AVS = 2, AVB = 2, AVA = 5,  AVF = 1;
  // Mode B: HTOT 22, VTOT 13, active h 9..18, v 5..10
  localparam int unsigned BHS = 5, BHB = 4, BHA = 10, BHF = 3;
  localparam int unsigned BVS = 2, BVB = 3, BVA = 6,  BVF = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic mode_sel = 1'b0;

  logic          d0_mode_cur, d0_running, d0_loc_valid, d0_hs, d0_vs, d0_de, d0_fs, d0_ls;
  logic          d1_mode_cur, d1_running, d1_loc_valid, d1_hs, d1_vs, d1_de, d1_fs, d1_ls;
  logic          d3_mode_cur, d3_running, d3_loc_valid, d3_hs, d3_vs, d3_de, d3_fs, d3_ls;
  logic [CW-1:0] d0_loc_x, d0_loc_y, d1_loc_x, d1_loc_y, d3_loc_x, d3_loc_y;

  hdmi_timing_gen #(.CW(CW), .PIPE_DLY(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .A_HSYNC(AHS), .A_HBP(AHB), .A_HACT(AHA), .A_HFP(AHF), .A_VSYNC(AVS), .A_VBP(AVB), .A_VACT(AVA), .A_VFP(AVF),
    .B_HSYNC(BHS), .B_HBP(BHB), .B_HACT(BHA), .B_HFP(BHF), .B_VSYNC(BVS), .B_VBP(BVB), .B_VACT(BVA), .B_VFP(BVF)
  ) u_d0 (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .mode_sel(mode_sel),
    .mode_cur(d0_mode_cur), .running(d0_running), .loc_x(d0_loc_x), .loc_y(d0_loc_y),
    .loc_valid(d0_loc_valid), .hdmi_hsync(d0_hs), .hdmi_vsync(d0_vs), .hdmi_de(d0_de),
    .frame_start(d0_fs), .line_start(d0_ls));

  hdmi_timing_gen #(.CW(CW), .PIPE_DLY(0), .HS_POL(1'b0), .VS_POL(1'b0),
    .A_HSYNC(AHS), .A_HBP(AHB), .A_HACT(AHA), .A_HFP(AHF), .A_VSYNC(AVS), .A_VBP(AVB), .A_VACT(AVA), .A_VFP(AVF),
    .B_HSYNC(BHS), .B_HBP(BHB), .B_HACT(BHA), .B_HFP(BHF), .B_VSYNC(BVS), .B_VBP(BVB), .B_VACT(BVA), .B_VFP(BVF)
  ) u_d1 (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .mode_sel(mode_sel),
    .mode_cur(d1_mode_cur), .running(d1_running), .loc_x(d1_loc_x), .loc_y(d1_loc_y),
    .loc_valid(d1_loc_valid), .hdmi_hsync(d1_hs), .hdmi_vsync(d1_vs), .hdmi_de(d1_de),
    .frame_start(d1_fs), .line_start(d1_ls));

  hdmi_timing_gen #(.CW(CW), .PIPE_DLY(3), .HS_POL(1'b1), .VS_POL(1'b1),
    .A_HSYNC(AHS), .A_HBP(AHB), .A_HACT(AHA), .A_HFP(AHF), .A_VSYNC(AVS), .A_VBP(AVB), .A_VACT(AVA), .A_VFP(AVF),
    .B_HSYNC(BHS), .B_HBP(BHB), .B_HACT(BHA), .B_HFP(BHF), .B_VSYNC(BVS), .B_VBP(BVB), .B_VACT(BVA), .B_VFP(BVF)
  ) u_d3 (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .mode_sel(mode_sel),
    .mode_cur(d3_mode_cur), .running(d3_running), .loc_x(d3_loc_x), .loc_y(d3_loc_y),
    .loc_valid(d3_loc_valid), .hdmi_hsync(d3_hs), .hdmi_vsync(d3_vs), .hdmi_de(d3_de),
    .frame_start(d3_fs), .line_start(d3_ls));

  int checks = 0;
  int errors = 0;

  // Frame measurement results (indices relative to d0 frame_start)
  int m_period, m_hs, m_vs, m_de, m_lv, m_ls, m_maxx, m_maxy;
  int m_first_lv, m_lx0, m_ly0, m_de0, m_de1, m_de3;
  int m_d1_hs_lo, m_d1_vs_lo, m_hs_at0, m_vs_at0, m_mode_mid, m_run_fall, m_fs_extra;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_fs(input int budget);
    int i;
    i = 0;
    while (!d0_fs && i < budget) begin
      step();
      i++;
    end
    checks++;
    if (d0_fs !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame_start: no frame_start within %0d cycles", budget);
    end
  endtask

  // Samples one frame starting at a d0 frame_start; optionally changes inputs mid-frame
  task automatic measure_frame(input int chg_at, input logic new_sel, input logic new_en,
                               input bit expect_next, input int budget);
    int i;
    i = 0;
    m_period = -1; m_hs = 0; m_vs = 0; m_de = 0; m_lv = 0; m_ls = 0; m_maxx = -1; m_maxy = -1;
    m_first_lv = -1; m_lx0 = -1; m_ly0 = -1; m_de0 = -1; m_de1 = -1; m_de3 = -1;
    m_d1_hs_lo = 0; m_d1_vs_lo = 0; m_mode_mid = -1; m_run_fall = -1; m_fs_extra = 0;
    m_hs_at0 = int'(d0_hs); m_vs_at0 = int'(d0_vs);
    while (1) begin
      m_hs += int'(d0_hs);
      m_vs += int'(d0_vs);
      m_de += int'(d0_de);
      m_lv += int'(d0_loc_valid);
      m_ls += int'(d0_ls);
      m_d1_hs_lo += int'(!d1_hs);
      m_d1_vs_lo += int'(!d1_vs);
      if (i > 0 && d0_fs) m_fs_extra++;
      if (d0_loc_valid) begin
        if (int'(d0_loc_x) > m_maxx) m_maxx = int'(d0_loc_x);
        if (int'(d0_loc_y) > m_maxy) m_maxy = int'(d0_loc_y);
        if (m_first_lv < 0) begin
          m_first_lv = i; m_lx0 = int'(d0_loc_x); m_ly0 = int'(d0_loc_y);
        end
      end
      if (d0_de && m_de0 < 0) m_de0 = i;
      if (d1_de && m_de1 < 0) m_de1 = i;
      if (d3_de && m_de3 < 0) m_de3 = i;
      if (!d0_running && m_run_fall < 0) m_run_fall = i;
      if (i == chg_at + 5) m_mode_mid = int'(d0_mode_cur);
      if (i == chg_at) begin
        mode_sel = new_sel;
        en = new_en;
      end
      step();
      i++;
      if (expect_next && d0_fs) begin
        m_period = i;
        break;
      end
      if (i >= budget) break;
    end
  endtask

  task automatic test_reset();
    logic [CW-1:0] vals [12];
    logic [CW-1:0] exps [12];
    string nm [12] = '{"rst_mode_cur", "rst_running", "rst_loc_valid", "rst_loc_x", "rst_loc_y",
                       "rst_de", "rst_hsync_hi", "rst_vsync_hi", "rst_frame_start", "rst_line_start",
                       "rst_hsync_lo", "rst_vsync_lo"};
    reset_n = 1'b0; en = 1'b0; mode_sel = 1'b0;
    repeat (3) step();
    vals = '{CW'(d0_mode_cur), CW'(d0_running), CW'(d0_loc_valid), d0_loc_x, d0_loc_y,
             CW'(d0_de), CW'(d0_hs), CW'(d0_vs), CW'(d0_fs), CW'(d0_ls), CW'(d1_hs), CW'(d1_vs)};
    exps = '{CW'(0), CW'(0), CW'(0), CW'(0), CW'(0), CW'(0), CW'(0), CW'(0), CW'(0), CW'(0), CW'(1), CW'(1)};
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (vals[k] !== exps[k]) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm[k], vals[k], exps[k]);
      end
    end
    reset_n = 1'b1;
    repeat (4) step();
    checks++;
    if (d0_running !== 1'b0 || d0_de !== 1'b0) begin
      errors++;
      $display("FAIL idle_with_en_low: running %0b de %0b expected 0 0", d0_running, d0_de);
    end
  endtask

  // en raised now: running after 1 edge, frame_start after 2+PIPE_DLY edges
  task automatic test_start();
    int run_c, fs0_c, fs1_c, fs3_c;
    run_c = -1; fs0_c = -1; fs1_c = -1; fs3_c = -1;
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (d0_running && run_c < 0) run_c = c;
      if (d0_fs && fs0_c < 0) fs0_c = c;
      if (d1_fs && fs1_c < 0) fs1_c = c;
      if (d3_fs && fs3_c < 0) fs3_c = c;
    end
    checks++;
    if (run_c != 1) begin errors++; $display("FAIL start_running: got cycle %0d expected 1", run_c); end
    checks++;
    if (fs1_c != 2) begin errors++; $display("FAIL start_fs_dly0: got cycle %0d expected 2", fs1_c); end
    checks++;
    if (fs0_c != 3) begin errors++; $display("FAIL start_fs_dly1: got cycle %0d expected 3", fs0_c); end
    checks++;
    if (fs3_c != 5) begin errors++; $display("FAIL start_fs_dly3: got cycle %0d expected 5", fs3_c); end
  endtask

  task automatic test_frame_a();
    int got [18];
    int exp [18];
    string nm [18] = '{"a_period", "a_hsync_cnt", "a_vsync_cnt", "a_de_cnt", "a_loc_valid_cnt",
                       "a_line_start_cnt", "a_max_x", "a_max_y", "a_first_valid", "a_first_x",
                       "a_first_y", "a_de_dly1", "a_de_dly0", "a_de_dly3", "a_hsync_low_cnt",
                       "a_vsync_low_cnt", "a_hsync_at_fs", "a_vsync_at_fs"};
    wait_fs(400);
    measure_frame(-1, mode_sel, en, 1'b1, 400);
    got = '{m_period, m_hs, m_vs, m_de, m_lv, m_ls, m_maxx, m_maxy, m_first_lv, m_lx0,
            m_ly0, m_de0, m_de1, m_de3, m_d1_hs_lo, m_d1_vs_lo, m_hs_at0, m_vs_at0};
    exp = '{170, 40, 34, 40, 40, 10, 7, 4, 74, 0, 0, 75, 74, 77, 40, 34, 1, 1};
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (got[k] != exp[k]) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm[k], got[k], exp[k]);
      end
    end
  endtask

  task automatic test_mode_switch();
    int got [16];
    int exp [16];
    string nm [16] = '{"sw_old_period", "sw_old_de_cnt", "sw_old_max_x", "sw_old_max_y", "sw_mode_mid",
                       "sw_mode_after", "b_period", "b_hsync_cnt", "b_vsync_cnt", "b_de_cnt",
                       "b_line_start_cnt", "b_max_x", "b_max_y", "b_first_valid", "b_de_dly1",
                       "b_de_dly3"};
    measure_frame(50, 1'b1, 1'b1, 1'b1, 400);
    got[0] = m_period; got[1] = m_de; got[2] = m_maxx; got[3] = m_maxy; got[4] = m_mode_mid;
    got[5] = int'(d0_mode_cur);
    measure_frame(-1, 1'b1, 1'b1, 1'b1, 400);
    got[6] = m_period; got[7] = m_hs; got[8] = m_vs; got[9] = m_de; got[10] = m_ls;
    got[11] = m_maxx; got[12] = m_maxy; got[13] = m_first_lv; got[14] = m_de0; got[15] = m_de3;
    exp = '{170, 40, 7, 4, 0, 1, 286, 65, 44, 60, 13, 9, 5, 118, 119, 121};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got[k] != exp[k]) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm[k], got[k], exp[k]);
      end
    end
  endtask

  task automatic test_stop();
    int got [12];
    int exp [12];
    string nm [12] = '{"stop_de_cnt", "stop_run_fall", "stop_extra_fs", "stop_running", "stop_de",
                       "stop_de_dly3", "stop_hsync_hi", "stop_hsync_lo", "stop_vsync_lo", "stop_loc_valid",
                       "stop_line_start", "stop_mode_cur"};
    // measure_frame leaves us on a mode B frame_start
    measure_frame(100, 1'b1, 1'b0, 1'b0, 300);
    repeat (5) step();
    got = '{m_de, m_run_fall, m_fs_extra, int'(d0_running), int'(d0_de), int'(d3_de), int'(d0_hs),
            int'(d1_hs), int'(d1_vs), int'(d0_loc_valid), int'(d3_ls), int'(d0_mode_cur)};
    exp = '{60, 284, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (got[k] != exp[k]) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm[k], got[k], exp[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    int got [12];
    int exp [12];
    string nm [12] = '{"arst_mode_cur", "arst_running", "arst_loc_valid", "arst_loc_x", "arst_de",
                       "arst_de_dly3", "arst_hsync_hi", "arst_hsync_lo", "arst_vsync_lo", "arst_frame_start",
                       "arst_line_start", "arst_vsync_hi"};
    int first_c;
    logic first_fs;
    mode_sel = 1'b0;
    wait_fs(400);
    repeat (80) step();
    #2 reset_n = 1'b0;
    #1;
    got = '{int'(d0_mode_cur), int'(d0_running), int'(d0_loc_valid), int'(d0_loc_x), int'(d0_de),
            int'(d3_de), int'(d0_hs), int'(d1_hs), int'(d1_vs), int'(d0_fs), int'(d3_ls), int'(d3_vs)};
    exp = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (got[k] != exp[k]) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm[k], got[k], exp[k]);
      end
    end
    repeat (2) step();
    reset_n = 1'b1;
    first_c = -1;
    first_fs = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if ((d0_ls || d0_fs) && first_c < 0) begin
        first_c = c;
        first_fs = d0_fs;
        break;
      end
    end
    checks++;
    if (first_c != 3 || first_fs !== 1'b1) begin
      errors++;
      $display("FAIL arst_first_strobe: got cycle %0d fs %0b expected cycle 3 fs 1", first_c, first_fs);
    end
    if (first_c > 0) begin
      measure_frame(-1, 1'b0, 1'b1, 1'b1, 400);
      checks++;
      if (m_period != 170 || m_de != 40) begin
        errors++;
        $display("FAIL arst_full_frame: got period %0d de %0d expected 170 40", m_period, m_de);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_frame_a();
    test_mode_switch();
    test_stop();
    test_start();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
